// File: rtl/debounce_switch.sv
//------------------------------------------------------------------------------
// Module      : debounce_switch
// Description : Synchronizes a raw mechanical switch and accepts a new level only
//               after it persists for DEBOUNCE_LIMIT cycles. When the macro
//               DEBOUNCE_SWITCH_EDGE_EN is defined, the module also generates
//               registered rise and fall pulses.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module debounce_switch #(
    parameter int DEBOUNCE_LIMIT = 250000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic i_Switch,
    output logic o_Switch,
    output logic o_Rise,
    output logic o_Fall
);

    localparam int              CNT_W   = $clog2(DEBOUNCE_LIMIT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_LIMIT - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic [CNT_W-1:0]       count_q;
    logic [CNT_W-1:0]       count_d;
    logic                   switch_q;
    logic                   switch_d;
    logic                   sync;

    assign sync = sync_q[SYNC_STAGES-1];

    always_comb begin
        // The truncating cast drops the oldest stage, which keeps the shift valid for SYNC_STAGES == 1.
        sync_d   = SYNC_STAGES'({sync_q, i_Switch});
        count_d  = '0;
        switch_d = switch_q;
        if (sync != switch_q) begin
            if (count_q == CNT_MAX) begin
                switch_d = sync;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q   <= '0;
            count_q  <= '0;
            switch_q <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            count_q  <= count_d;
            switch_q <= switch_d;
        end
    end

    assign o_Switch = switch_q;

`ifdef DEBOUNCE_SWITCH_EDGE_EN
    logic rise_q;
    logic rise_d;
    logic fall_q;
    logic fall_d;

    // Each pulse is registered on the same edge that loads switch_q. As a result, the pulse lines up with the new level.
    always_comb begin
        rise_d = switch_d & ~switch_q;
        fall_d = ~switch_d & switch_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign o_Rise = rise_q;
    assign o_Fall = fall_q;
`else
    assign o_Rise = 1'b0;
    assign o_Fall = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_debounce_switch.sv
//------------------------------------------------------------------------------
// Module      : tb_debounce_switch
// Description : Self-checking bench for debounce_switch, with directed scenarios
//               and random bounce patterns compared against a reference model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_debounce_switch;

    localparam int LIMIT = 4;
    localparam int SYNC  = 2;
    localparam int LAT   = SYNC + LIMIT;
`ifdef DEBOUNCE_SWITCH_EDGE_EN
    localparam bit EDGE_EN = 1'b1;
`else
    localparam bit EDGE_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    logic i_Switch;
    logic o_Switch;
    logic o_Rise;
    logic o_Fall;

    int errors = 0;
    int checks = 0;

    // Reference model: input delayed by SYNC cycles, plus a count of consecutive disagreeing cycles.
    bit m_pipe[$];
    bit m_out;
    bit m_rise;
    bit m_fall;
    int m_run;

    debounce_switch #(
        .DEBOUNCE_LIMIT(LIMIT),
        .SYNC_STAGES   (SYNC)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .i_Switch(i_Switch),
        .o_Switch(o_Switch),
        .o_Rise  (o_Rise),
        .o_Fall  (o_Fall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
            $error("check %s disagreed", tag);
        end
    endtask

    task automatic model_clear();
        m_pipe = {};
        for (int i = 0; i < SYNC; i++) m_pipe.push_back(1'b0);
        m_out  = 1'b0;
        m_rise = 1'b0;
        m_fall = 1'b0;
        m_run  = 0;
    endtask

    // Drive one input value, advance by one rising edge, update the model, and compare all outputs.
    task automatic tick(input bit in);
        bit s;
        i_Switch = in;
        @(posedge clk);
        if (reset) begin
            model_clear();
        end else begin
            s      = m_pipe[SYNC-1];
            m_rise = 1'b0;
            m_fall = 1'b0;
            if (s != m_out) m_run++;
            else            m_run = 0;
            if (m_run == LIMIT) begin
                m_out  = s;
                m_run  = 0;
                m_rise = EDGE_EN & s;
                m_fall = EDGE_EN & ~s;
            end
            m_pipe.push_front(in);
            void'(m_pipe.pop_back());
        end
        #1;
        chk("o_Switch", {31'd0, o_Switch}, {31'd0, m_out});
        chk("o_Rise",   {31'd0, o_Rise},   {31'd0, m_rise});
        chk("o_Fall",   {31'd0, o_Fall},   {31'd0, m_fall});
        chk("no_both",  {31'd0, o_Rise & o_Fall}, 32'd0);
        @(negedge clk);
    endtask

    // Hold the input, and return the number of edges until o_Switch reaches target. The bound is 20 edges.
    task automatic hold_until(input bit in, input bit target, output int n);
        n = 0;
        for (int k = 1; k <= 20; k++) begin
            tick(in);
            if (o_Switch == target) begin
                n = k;
                break;
            end
        end
    endtask

    initial begin
        int n;
        int len;
        bit lvl;
        reset    = 1'b1;
        i_Switch = 1'b0;
        model_clear();
        @(negedge clk);
        #1;
        chk("rst_switch", {31'd0, o_Switch}, 32'd0);
        chk("rst_rise",   {31'd0, o_Rise},   32'd0);
        chk("rst_fall",   {31'd0, o_Fall},   32'd0);
        tick(1'b0);
        reset = 1'b0;
        for (int k = 0; k < 8; k++) tick(1'b0);

        // Held rise and held fall. Each change must appear on the 6th edge with a single pulse.
        hold_until(1'b1, 1'b1, n);
        chk("rise_latency", n, LAT);
        chk("rise_pulse", {31'd0, o_Rise}, {31'd0, EDGE_EN});
        tick(1'b1);
        chk("rise_pulse_end", {31'd0, o_Rise}, 32'd0);
        for (int k = 0; k < 4; k++) tick(1'b1);
        hold_until(1'b0, 1'b0, n);
        chk("fall_latency", n, LAT);
        chk("fall_pulse", {31'd0, o_Fall}, {31'd0, EDGE_EN});
        for (int k = 0; k < 8; k++) tick(1'b0);

        // A short glitch of 3 cycles must be rejected.
        for (int k = 0; k < 3; k++) tick(1'b1);
        for (int k = 0; k < 12; k++) tick(1'b0);
        chk("glitch_rejected", {31'd0, o_Switch}, 32'd0);

        // Bounce pattern of high 3, low 1, then high. The switch must rise 6 edges after the final change.
        for (int k = 0; k < 3; k++) tick(1'b1);
        tick(1'b0);
        hold_until(1'b1, 1'b1, n);
        chk("bounce_latency", n, LAT);
        for (int k = 0; k < 4; k++) tick(1'b1);
        for (int k = 0; k < 10; k++) tick(1'b0);

        // Assert reset 4 edges into a held change. The full latency must restart after release.
        for (int k = 0; k < 4; k++) tick(1'b1);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_switch", {31'd0, o_Switch}, 32'd0);
        @(negedge clk);
        for (int k = 0; k < 3; k++) tick(1'b1);
        reset = 1'b0;
        hold_until(1'b1, 1'b1, n);
        chk("post_reset_latency", n, LAT);
        chk("post_reset_rise", {31'd0, o_Rise}, {31'd0, EDGE_EN});
        for (int k = 0; k < 4; k++) tick(1'b1);

        // Random segments whose hold lengths straddle the debounce limit.
        lvl = 1'b1;
        for (int s = 0; s < 300; s++) begin
            lvl = ~lvl;
            len = $urandom_range(1, 9);
            for (int k = 0; k < len; k++) tick(lvl);
        end
        for (int k = 0; k < 10; k++) tick(1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
